fir_mac_scheduler: RTL and testbench
====================================

# fir_mac_scheduler

Sequencer for a time-multiplexed FIR equalizer. It accepts one input sample per handshake and stores it in a circular delay line. It then runs one shared multiplier-accumulator over all taps, one tap per cycle, and presents the full-precision filter output with a valid/ready handshake. It sits between the sample source and the equalizer output stage, and it also owns the writable coefficient bank.

## Interface
- TAPS, 8: number of filter taps (≥2, power of two).
- DW, 16: signed sample width.
- CW, 16: signed coefficient width.
- ACC_W, 35: signed accumulator/output width, at least DW+CW+log2(TAPS).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  scheduler can accept a sample.
- in_data  in  DW  signed input sample x[n].
- out_valid  out  1  filter result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  signed y[n].
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  log2(TAPS)  tap index k.
- coef_data  in  CW  signed coefficient c[k].
- coef_err  out  1  one-cycle pulse: a write was dropped.
- busy  out  1  high in MAC state.

## Operation
- Filter: y[n] = Σ c[k]·x[n−k] for k=0..TAPS−1. Samples older than the first accepted sample after reset are 0.
- Storage:
  - sample RAM of TAPS×DW and write pointer wp, both cleared on reset.
  - coefficient bank of TAPS×CW, cleared to 0 on reset.
- States:
  - IDLE: in_ready=1. On in_valid, write in_data at wp, clear acc, set k=0, then go to MAC. The pointer wp advances at the end of MAC.
  - MAC: each cycle acc ← acc + sext(c[k])·sext(x[(wp−k) mod TAPS]), then k←k+1. After the k=TAPS−1 cycle, register out_data←final sum, advance wp (mod TAPS, wrapping TAPS−1→0), and go to HOLD.
  - HOLD: out_valid=1, with out_data stable until handshake. in_ready = out_ready.
    - If out_ready and in_valid: accept the new sample in the same cycle and go to MAC.
    - If out_ready and no in_valid: go to IDLE.
    - If no out_ready: stay in HOLD.
- Coefficients:
  - coef_we in IDLE or HOLD writes c[coef_addr] at the edge. The new value is used by the next MAC pass.
  - coef_we in MAC is dropped and coef_err pulses high the next cycle; the bank is unchanged.
- Arithmetic: two's complement products are sign-extended to ACC_W with no saturation. ACC_W is sized so overflow is impossible.
- Reset mid-operation: an in-flight pass is discarded. State goes to IDLE; sample RAM, coefficients, wp, acc and outputs are cleared.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, coef_err=0, busy=0.
  - in_ready is 0 during reset assertion.
- Latency: for a sample accepted at edge E0, busy is high for cycles E0..E0+TAPS−1 and out_valid rises after edge E0+TAPS.
- Throughput:
  - Back-to-back operation (in_valid and out_ready held high) gives one result per TAPS+1 cycles.
  - Operation with an IDLE bubble gives one result per TAPS+2 cycles.
- in_ready is 0 throughout MAC. A held in_valid is not consumed until in_ready is high.
- out_valid stays high until the out_ready handshake. out_data must not change while out_valid=1 and out_ready=0.
- Simultaneous out handshake and in accept in HOLD: both complete at the same edge. out_valid goes low for TAPS cycles, then the new result appears.
- coef_we at the same edge as an IDLE acceptance: the write lands before MAC begins and is used by this pass.

## Test plan
- Impulse response: load c=1,2,…,8, feed x=1 then nine 0s → y=1,2,3,4,5,6,7,8,0,0.
- Step response: all c=3, feed x=100 repeatedly → y=300,600,…,2400, then stays at 2400 (exercises wp wrap).
- Signed extremes: all c=−32768, feed x=−32768 for 8 samples → final y=8589934592 (2^33) with no overflow. Then feed x=32767 with c=32767 on all taps → the result equals the exact sum.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out_data stable, in_ready=0, no extra sample consumed. Release → handshake, then the next sample is accepted that same cycle if in_valid=1.
- Coef write while busy: coef_we(addr 0, value 5) during cycle 3 of MAC → coef_err pulses one cycle, c[0] unchanged. The same write in IDLE takes effect on the next y.
- Reset mid-MAC: assert rst_n=0 at MAC cycle 4 → all outputs at reset values. Then c=1 on tap 0 only, feed x=7 → y=7, showing the delay line was cleared.

Source files
------------

// File: rtl/fir_mac_scheduler.sv
// -----------------------------------------------------------------------------
// fir_mac_scheduler
//
// Sequencer for a time-multiplexed FIR equalizer. Each accepted sample is
// written into a circular delay line. A single shared multiplier-accumulator
// then walks all taps, one tap per cycle, and the full-precision result is
// presented on a valid/ready output. The block also owns the writable
// coefficient bank.
//
// Parameters:
//   TAPS  - number of taps (power of two, >= 2)
//   DW    - signed sample width
//   CW    - signed coefficient width
//   ACC_W - signed accumulator / output width (>= DW+CW+log2(TAPS))
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   - sample handshake, in_data = x[n]
//   out_valid/out_ready - result handshake, out_data = y[n]
//   coef_we/addr/data   - coefficient write port (dropped while busy)
//   coef_err            - one-cycle pulse after a dropped coefficient write
//   busy                - high while the MAC pass runs
// -----------------------------------------------------------------------------
module fir_mac_scheduler #(
    parameter int TAPS  = 8,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int ACC_W = 35
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DW-1:0]     in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [CW-1:0]     coef_data,
    output logic                     coef_err,
    output logic                     busy
);

    localparam int AW = $clog2(TAPS);
    localparam int PW = DW + CW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  state_r;
    logic signed [DW-1:0]    sample_mem_r [TAPS];
    logic signed [CW-1:0]    coef_mem_r   [TAPS];
    logic [AW-1:0]           wp_r;
    logic [AW-1:0]           k_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] out_data_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic                    coef_err_r;

    logic                    in_ready_s;
    logic                    accept_s;
    logic [AW-1:0]           samp_idx_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [ACC_W-1:0] acc_sum_s;

    // Input readiness: IDLE always, HOLD only when the result is being taken
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: in_ready_s = 1'b1;
            ST_HOLD: in_ready_s = out_ready;
            ST_MAC:  in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // in_ready is forced low while reset is asserted
    assign in_ready = in_ready_s & rst_n;
    assign accept_s = in_valid & in_ready_s;

    // One MAC step: x index wraps naturally because TAPS is a power of two
    always_comb begin
        samp_idx_s = wp_r - k_r;
        prod_s     = PW'(coef_mem_r[k_r]) * PW'(sample_mem_r[samp_idx_s]);
        acc_sum_s  = acc_r + {{(ACC_W-PW){prod_s[PW-1]}}, prod_s};
    end

    // Sequencer FSM: state, tap counter, write pointer, accumulator, result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            wp_r        <= '0;
            k_r         <= '0;
            acc_r       <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_r   <= '0;
                        k_r     <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_MAC;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MAC: begin
                    if (k_r == AW'(TAPS - 1)) begin
                        // Last tap: publish the sum and move to the next slot
                        out_data_r  <= acc_sum_s;
                        acc_r       <= acc_sum_s;
                        wp_r        <= wp_r + AW'(1);
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_HOLD;
                    end else begin
                        acc_r <= acc_sum_s;
                        k_r   <= k_r + AW'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (in_valid) begin
                            // Result handshake and new sample at the same edge
                            acc_r   <= '0;
                            k_r     <= '0;
                            busy_r  <= 1'b1;
                            state_r <= ST_MAC;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Sample delay line: written at wp on every accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                sample_mem_r[i] <= '0;
            end
        end else begin
            if (accept_s) begin
                sample_mem_r[wp_r] <= in_data;
            end else begin
                sample_mem_r[wp_r] <= sample_mem_r[wp_r];
            end
        end
    end

    // Coefficient bank: writes land outside MAC, writes during MAC flag an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_mem_r[i] <= '0;
            end
            coef_err_r <= 1'b0;
        end else begin
            coef_err_r <= coef_we & (state_r == ST_MAC);
            if (coef_we && (state_r != ST_MAC)) begin
                coef_mem_r[coef_addr] <= coef_data;
            end else begin
                coef_mem_r[coef_addr] <= coef_mem_r[coef_addr];
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign coef_err  = coef_err_r;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for fir_mac_scheduler. Expected results come from a
// direct convolution over a sample history and a coefficient table.
// -----------------------------------------------------------------------------
module tb_fir_mac_scheduler;

    localparam int TAPS  = 8;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int ACC_W = 35;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [DW-1:0]    in_data = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic signed [ACC_W-1:0] out_data;
    logic                    coef_we = 1'b0;
    logic [2:0]              coef_addr = '0;
    logic signed [CW-1:0]    coef_data = '0;
    logic                    coef_err;
    logic                    busy;

    int tests = 0;
    int fails = 0;

    longint m_coef [TAPS];
    longint m_hist [TAPS];   // m_hist[0] is the newest sample

    fir_mac_scheduler #(.TAPS(TAPS), .DW(DW), .CW(CW), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_err(coef_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += m_coef[k] * m_hist[k];
        return s;
    endfunction

    task automatic model_push(input longint x);
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = x;
    endtask

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
    endtask

    // Idle-time coefficient write
    task automatic write_coef(input int a, input logic signed [CW-1:0] d);
        coef_we = 1'b1; coef_addr = a[2:0]; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
        m_coef[a] = d;
        chk("coef_err_idle", coef_err, 0);
    endtask

    // Called on the first negedge after the accepting edge
    task automatic finish_result(input int hold);
        int cyc;
        logic signed [ACC_W-1:0] held;
        chk("busy_in_mac", busy, 1);
        chk("in_ready_in_mac", in_ready, 0);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, TAPS + 1);
        chk("y", out_data, model_y());
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_stable", out_data, held);
            chk("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_after_hs", out_valid, 0);
    endtask

    // Wait for in_ready, present one sample (optionally with a coef write), finish
    task automatic run(input logic signed [DW-1:0] x, input int hold, input bit cw,
                       input int ca, input logic signed [CW-1:0] cd);
        int cyc = 0;
        while (!in_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready_wait", in_ready, 1);
        in_valid = 1'b1; in_data = x;
        coef_we = cw; coef_addr = ca[2:0]; coef_data = cd;
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b0;
        if (cw) m_coef[ca] = cd;
        model_push(x);
        finish_result(hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_coef_err"}, coef_err, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic signed [ACC_W-1:0] held;
        logic signed [DW-1:0] rx;
        logic signed [CW-1:0] rc;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        chk("in_ready_in_reset", in_ready, 0);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        check_reset_outputs("post_rst");

        // Impulse response
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));
        run(16'sd1, 0, 1'b0, 0, 16'sd0);
        for (int i = 0; i < 9; i++) run(16'sd0, 0, 1'b0, 0, 16'sd0);

        // Step response, runs past the pointer wrap
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sd3);
        for (int i = 0; i < 10; i++) run(16'sd100, 0, 1'b0, 0, 16'sd0);
        chk("step_settled", out_data, 64'sd2400);

        // Signed extremes
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sh8000);
        for (int i = 0; i < TAPS; i++) run(16'sh8000, 0, 1'b0, 0, 16'sd0);
        chk("neg_extreme", out_data, 64'sd8589934592);
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sh7fff);
        for (int i = 0; i < TAPS; i++) run(16'sh7fff, 0, 1'b0, 0, 16'sd0);
        chk("pos_extreme", out_data, 64'sd8589410312);

        // Backpressure with a held in_valid, then same-edge handshake + accept
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k - 3));
        in_valid = 1'b1; in_data = 16'sd55;
        @(negedge clk);
        model_push(55);
        in_data = 16'sd77;      // stays presented; must not be consumed yet
        chk("bp_busy", busy, 1);
        while (!out_valid && busy) @(negedge clk);
        chk("bp_y", out_data, model_y());
        held = out_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_stable", out_data, held);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        model_push(77);
        chk("bp_valid_drop", out_valid, 0);
        finish_result(0);

        // Coefficient write while busy is dropped
        in_valid = 1'b1; in_data = 16'sd9;
        @(negedge clk);
        in_valid = 1'b0;
        model_push(9);
        @(negedge clk);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd5;
        @(negedge clk);
        coef_we = 1'b0;
        chk("coef_err_pulse", coef_err, 1);
        @(negedge clk);
        chk("coef_err_one_cycle", coef_err, 0);
        while (!out_valid && busy) @(negedge clk);
        chk("coef_drop_y", out_data, model_y());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        write_coef(0, 16'sd5);
        run(16'sd4, 0, 1'b0, 0, 16'sd0);

        // Coefficient write on the accepting edge is used by that pass
        run(16'sd11, 1, 1'b1, 7, 16'sd100);

        // Reset mid-MAC
        in_valid = 1'b1; in_data = 16'sd21;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        chk("midrst_in_ready_after", in_ready, 1);
        write_coef(0, 16'sd1);
        run(16'sd7, 0, 1'b0, 0, 16'sd0);
        chk("midrst_y7", out_data, 64'sd7);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rx = 16'($urandom);
            rc = 16'($urandom);
            if ($urandom_range(0, 2) == 0) write_coef(int'($urandom_range(0, TAPS - 1)), rc);
            rc = 16'($urandom);
            run(rx, int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                int'($urandom_range(0, TAPS - 1)), rc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
